// File: rtl/uart_controller_param.sv
// Parametrised UART controller: TX/RX FIFOs, bit-serial TX/RX FSMs, sticky error flags.
// Optional feature macro: UART_PARITY_EN (adds one parity bit per frame on TX and RX).
// With parity enabled, the parity bit is carried as the last bit of the frame shift
// register, so the DATA state covers DATA_BITS+1 bit times.
module uart_controller_param #(
   parameter int CLKS_PER_BIT  = 5208,
   parameter int DATA_BITS     = 8,
   parameter int STOP_BITS     = 1,
   parameter int FIFO_RX_DEPTH = 16,
   parameter int FIFO_TX_DEPTH = 16,
   parameter int PARITY_ODD    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 UART_TXD,
   input  logic                 UART_RXD,
   input  logic                 WE,
   input  logic [DATA_BITS-1:0] send_data,
   input  logic                 RE,
   output logic [DATA_BITS-1:0] receive_data,
   output logic                 tx_full,
   output logic                 rx_empty,
   output logic                 tx_idle,
   output logic                 rx_overrun,
   output logic                 frame_err,
   output logic                 parity_err,
   input  logic                 err_clr
);

`ifdef UART_PARITY_EN
   localparam int   PAR_BITS = 1;
   localparam logic PAR_ODD  = 1'(PARITY_ODD);
`else
   localparam int   PAR_BITS = 0;
`endif
   localparam int FW  = DATA_BITS + PAR_BITS;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(FW);
   localparam int TAW = $clog2(FIFO_TX_DEPTH);
   localparam int RAW = $clog2(FIFO_RX_DEPTH);
   localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF    = CW'(CLKS_PER_BIT / 2);
   localparam logic [BW-1:0] BIT_LAST    = BW'(FW - 1);
   localparam logic [BW-1:0] STOP_LAST   = BW'(STOP_BITS - 1);
   localparam logic [TAW:0]  TX_FULL_CNT = (TAW + 1)'(FIFO_TX_DEPTH);
   localparam logic [RAW:0]  RX_FULL_CNT = (RAW + 1)'(FIFO_RX_DEPTH);

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       FIFO_RX_DEPTH < 2 || (FIFO_RX_DEPTH & (FIFO_RX_DEPTH - 1)) != 0 ||
       FIFO_TX_DEPTH < 2 || (FIFO_TX_DEPTH & (FIFO_TX_DEPTH - 1)) != 0 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_controller_param: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // Frame payload as shifted out LSB first: data bits, then the parity bit if enabled.
   function automatic logic [FW-1:0] frame_word(input logic [DATA_BITS-1:0] d);
`ifdef UART_PARITY_EN
      return {(^d) ^ PAR_ODD, d};
`else
      return d;
`endif
   endfunction

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] tx_mem [FIFO_TX_DEPTH];
   logic [TAW-1:0]       tx_wr, tx_rd;
   logic [TAW:0]         tx_count;
   logic                 tx_push, tx_pop, tx_stop_end;
   logic [DATA_BITS-1:0] tx_head;
   state_t               tx_state;
   logic [CW-1:0]        tx_cnt;
   logic [BW-1:0]        tx_idx;
   logic [FW-1:0]        tx_shift;

   assign tx_full     = (tx_count == TX_FULL_CNT);
   assign tx_head     = tx_mem[tx_rd];
   assign tx_stop_end = (tx_state == S_STOP) && (tx_cnt == CNT_LAST) && (tx_idx == STOP_LAST);
   assign tx_pop      = (tx_count != '0) && ((tx_state == S_IDLE) || tx_stop_end);
   assign tx_push     = WE && (!tx_full || tx_pop);
   assign tx_idle     = (tx_count == '0) && (tx_state == S_IDLE);

   // TX FIFO storage write (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= send_data;
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_count <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end

   // TX FSM with registered line output; back-to-back frames go STOP -> START directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         UART_TXD <= 1'b1;
      end else begin
         case (tx_state)
            S_IDLE: begin
               UART_TXD <= 1'b1;
               if (tx_pop) begin
                  tx_state <= S_START;
                  tx_cnt   <= '0;
                  tx_shift <= frame_word(tx_head);
                  UART_TXD <= 1'b0;
               end
            end
            S_START: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_state <= S_DATA;
                  tx_cnt   <= '0;
                  tx_idx   <= '0;
                  UART_TXD <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_idx == BIT_LAST) begin
                     tx_state <= S_STOP;
                     tx_idx   <= '0;
                     UART_TXD <= 1'b1;
                  end else begin
                     tx_idx   <= tx_idx + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     UART_TXD <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_idx == STOP_LAST) begin
                     tx_idx <= '0;
                     if (tx_pop) begin
                        tx_state <= S_START;
                        tx_shift <= frame_word(tx_head);
                        UART_TXD <= 1'b0;
                     end else begin
                        tx_state <= S_IDLE;
                        UART_TXD <= 1'b1;
                     end
                  end else begin
                     tx_idx <= tx_idx + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               tx_state <= S_IDLE;
               UART_TXD <= 1'b1;
            end
         endcase
      end
   end

   // ---------------- RX path ----------------
   logic [DATA_BITS-1:0] rx_mem [FIFO_RX_DEPTH];
   logic [RAW-1:0]       rx_wr, rx_rd;
   logic [RAW:0]         rx_count;
   logic                 rx_full, rx_push, rx_pop, rx_stop_hit;
   logic                 rx_s1, rx_s2;
   state_t               rx_state;
   logic [CW-1:0]        rx_cnt;
   logic [BW-1:0]        rx_idx;
   logic [FW-1:0]        rx_shift;

   assign rx_empty     = (rx_count == '0);
   assign rx_full      = (rx_count == RX_FULL_CNT);
   assign rx_pop       = RE && !rx_empty;
   assign rx_stop_hit  = (rx_state == S_STOP) && (rx_cnt == CNT_LAST);
   assign rx_push      = rx_stop_hit && rx_s2 && (!rx_full || RE);
   assign receive_data = rx_mem[rx_rd];

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= UART_RXD;
         rx_s2 <= rx_s1;
      end
   end

   // RX FIFO storage and pointers; storage cleared so the show-ahead output is 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_RX_DEPTH; i++) rx_mem[i] <= '0;
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_count <= '0;
      end else begin
         if (rx_push) begin
            rx_mem[rx_wr] <= rx_shift[DATA_BITS-1:0];
            rx_wr         <= rx_wr + 1'b1;
         end
         if (rx_pop) rx_rd <= rx_rd + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   // RX FSM with mid-bit sampling and sticky error flags (a set event beats err_clr).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state   <= S_IDLE;
         rx_cnt     <= '0;
         rx_idx     <= '0;
         rx_shift   <= '0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (err_clr) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
         end
         case (rx_state)
            S_IDLE: begin
               if (!rx_s2) begin
                  rx_state <= S_START;
                  rx_cnt   <= '0;
               end
            end
            S_START: begin
               if (rx_cnt == CNT_HALF) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[FW-1:1]};
                  if (rx_idx == BIT_LAST) begin
                     rx_state <= S_STOP;
`ifdef UART_PARITY_EN
                     if ((^{rx_s2, rx_shift[FW-1:1]}) != PAR_ODD) parity_err <= 1'b1;
`endif
                  end else begin
                     rx_idx <= rx_idx + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= S_IDLE;
                  if (!rx_s2)                frame_err  <= 1'b1;
                  else if (rx_full && !RE)   rx_overrun <= 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

`ifndef UART_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_controller_param.sv
// Directed bench for uart_controller_param with a receive scoreboard.
module tb_uart_controller_param;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst, we, re, err_clr, loop, rxd_drv;
   logic       txd, rxd;
   logic [7:0] send_data, receive_data;
   logic       tx_full, rx_empty, tx_idle, rx_overrun, frame_err, parity_err;
   logic [7:0] sb[$];
   int         checks = 0;
   int         errors = 0;

   assign rxd = loop ? txd : rxd_drv;

   uart_controller_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1),
      .FIFO_RX_DEPTH(4), .FIFO_TX_DEPTH(4), .PARITY_ODD(0)
   ) dut (
      .clk(clk), .rst(rst), .UART_TXD(txd), .UART_RXD(rxd), .WE(we), .send_data(send_data),
      .RE(re), .receive_data(receive_data), .tx_full(tx_full), .rx_empty(rx_empty),
      .tx_idle(tx_idle), .rx_overrun(rx_overrun), .frame_err(frame_err),
      .parity_err(parity_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      int n = 0;
      while (tx_full && n < 2000) begin tick(1); n++; end
      if (tx_full) chk1("tx_full_wait", tx_full, 1'b0);
      we = 1'b1; send_data = d;
      tick(1);
      we = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (!tx_idle && n < bound) begin tick(1); n++; end
      chk1("tx_idle_wait", tx_idle, 1'b1);
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] e;
      if (sb.size() > 0) e = sb.pop_front();
      else e = 8'hEE;
      chk1({tag, "_nonempty"}, rx_empty, 1'b0);
      chk8(tag, receive_data, e);
      re = 1'b1;
      tick(1);
      re = 1'b0;
   endtask

   task automatic drive_frame(input logic [8:0] bits, input int nbits, input logic stopv);
      rxd_drv = 1'b0;
      tick(CPB);
      for (int i = 0; i < nbits; i++) begin
         rxd_drv = bits[i];
         tick(CPB);
      end
      rxd_drv = stopv;
      tick(CPB);
      rxd_drv = 1'b1;
      tick(2 * CPB);
   endtask

   initial begin
      logic [7:0] pat;
      int lows;
      rst = 1'b1; we = 1'b0; re = 1'b0; err_clr = 1'b0; send_data = 8'h00;
      loop = 1'b1; rxd_drv = 1'b1;
      tick(3);
      chk1("rst_txd", txd, 1'b1);
      chk1("rst_tx_full", tx_full, 1'b0);
      chk1("rst_rx_empty", rx_empty, 1'b1);
      chk1("rst_tx_idle", tx_idle, 1'b1);
      chk1("rst_overrun", rx_overrun, 1'b0);
      chk1("rst_frame_err", frame_err, 1'b0);
      chk1("rst_parity_err", parity_err, 1'b0);
      chk8("rst_receive_data", receive_data, 8'h00);
      rst = 1'b0;
      tick(2);

      // 1: single frame A5, bit-exact line levels and tx_idle timing
      pat = 8'hA5;
      we = 1'b1; send_data = pat;
      tick(1);
      we = 1'b0;
      chk1("t1_busy_after_we", tx_idle, 1'b0);
      chk1("t1_txd_before_start", txd, 1'b1);
      tick(1);
      chk1("t1_start_edge", txd, 1'b0);
      tick(8);
      chk1("t1_start_mid", txd, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(CPB);
         chk1($sformatf("t1_bit%0d", i), txd, pat[i]);
      end
`ifdef UART_PARITY_EN
      tick(CPB);
      chk1("t1_parity", txd, ^pat);
`endif
      tick(CPB);
      chk1("t1_stop", txd, 1'b1);
      tick(7);
      chk1("t1_idle_late", tx_idle, 1'b0);
      tick(1);
      chk1("t1_idle_on_time", tx_idle, 1'b1);
      sb.push_back(pat);
      tick(10);
      pop_check("t1_loop_data");
      chk1("t1_rx_drained", rx_empty, 1'b1);

      // 2: back-to-back loopback frames
      send(8'h00); sb.push_back(8'h00);
      send(8'hFF); sb.push_back(8'hFF);
      send(8'h3C); sb.push_back(8'h3C);
      tick(95);
      chk1("t2_empty_mid_frame1", rx_empty, 1'b1);
      begin
         int n = 0;
         while (rx_empty && n < 100) begin tick(1); n++; end
      end
      chk1("t2_first_frame_in", rx_empty, 1'b0);
      wait_idle(1000);
      tick(10);
      pop_check("t2_pop0");
      pop_check("t2_pop1");
      pop_check("t2_pop2");
      chk1("t2_rx_empty", rx_empty, 1'b1);
      chk1("t2_overrun", rx_overrun, 1'b0);
      chk1("t2_frame_err", frame_err, 1'b0);
      chk1("t2_parity_err", parity_err, 1'b0);

      // 3: RX FIFO overrun with depth 4
      for (int d = 1; d <= 5; d++) begin
         send(8'(d));
         if (d <= 4) sb.push_back(8'(d));
      end
      wait_idle(2000);
      tick(10);
      chk1("t3_overrun_set", rx_overrun, 1'b1);
      chk1("t3_no_frame_err", frame_err, 1'b0);
      for (int i = 0; i < 4; i++) pop_check($sformatf("t3_pop%0d", i));
      chk1("t3_rx_empty", rx_empty, 1'b1);
      re = 1'b1; tick(1); re = 1'b0;
      chk1("t3_pop_on_empty", rx_empty, 1'b1);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      chk1("t3_overrun_cleared", rx_overrun, 1'b0);

      // 4: framing error, glitch rejection, then a clean injected frame
      loop = 1'b0; rxd_drv = 1'b1;
      tick(5);
      drive_frame({1'b0, 8'h96}, 8, 1'b0);
      chk1("t4_frame_err", frame_err, 1'b1);
      chk1("t4_frame_not_pushed", rx_empty, 1'b1);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      chk1("t4_frame_err_cleared", frame_err, 1'b0);
      rxd_drv = 1'b0; tick(4); rxd_drv = 1'b1;
      tick(40);
      chk1("t4_glitch_no_push", rx_empty, 1'b1);
      chk1("t4_glitch_no_frame_err", frame_err, 1'b0);
      chk1("t4_glitch_no_overrun", rx_overrun, 1'b0);
`ifdef UART_PARITY_EN
      drive_frame({^8'h5A, 8'h5A}, 9, 1'b1);
`else
      drive_frame({1'b0, 8'h5A}, 8, 1'b1);
`endif
      sb.push_back(8'h5A);
      pop_check("t4_clean_frame");

      // 5: reset in the middle of a transmit with words still queued
      loop = 1'b1;
      send(8'hFF); send(8'h11); send(8'h22); send(8'h33);
      tick(60);
      rst = 1'b1;
      #1;
      chk1("t5_txd_on_rst", txd, 1'b1);
      chk1("t5_idle_on_rst", tx_idle, 1'b1);
      chk1("t5_full_on_rst", tx_full, 1'b0);
      chk1("t5_rx_empty_on_rst", rx_empty, 1'b1);
      tick(2);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (!txd) lows++;
      end
      chkn("t5_no_frames_after_rst", lows, 0);
      chk1("t5_idle_after_rst", tx_idle, 1'b1);
      chk1("t5_rx_empty_after_rst", rx_empty, 1'b1);

`ifdef UART_PARITY_EN
      // 6: even parity on TX, corrupted parity on RX still pushes the word
      send(8'h07);
      tick(1 + 8 + CPB * 9);
      chk1("t6_tx_parity_bit", txd, 1'b1);
      sb.push_back(8'h07);
      wait_idle(1000);
      tick(10);
      pop_check("t6_loop_data");
      chk1("t6_no_parity_err", parity_err, 1'b0);
      loop = 1'b0; rxd_drv = 1'b1;
      tick(5);
      drive_frame({1'b0, 8'h07}, 9, 1'b1);
      sb.push_back(8'h07);
      chk1("t6_parity_err", parity_err, 1'b1);
      chk1("t6_no_frame_err", frame_err, 1'b0);
      pop_check("t6_bad_parity_pushed");
`endif

      chkn("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_controller_param.md
Name: uart_controller_param

Overview:
Parametrised UART controller with generalised data width, stop-bit count and FIFO depths. Adds error reporting and reset that the first-generation controller lacked.
- Sits on the processor I/O bus and drives the DE2-115 UART pins.
- Internal TX and RX FIFOs decouple the CPU from the bit-serial line.
- Reports sticky overrun and framing errors, plus full/empty/idle status.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit; legal values are ≥ 4.
DATA_BITS, 8, data bits per frame; legal values are 5 to 9.
STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.
FIFO_RX_DEPTH, 16, RX FIFO entries; must be a power of 2, ≥ 2.
FIFO_TX_DEPTH, 16, TX FIFO entries; must be a power of 2, ≥ 2.
PARITY_ODD, 0, 1 selects odd parity, 0 selects even; used only with UART_PARITY_EN.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
UART_TXD  out  1  serial output, idles high
UART_RXD  in  1  serial input, asynchronous to clk
WE  in  1  push send_data into TX FIFO
send_data  in  DATA_BITS  word to transmit
RE  in  1  pop head of RX FIFO
receive_data  out  DATA_BITS  head of RX FIFO (show-ahead)
tx_full  out  1  TX FIFO full
rx_empty  out  1  RX FIFO empty
tx_idle  out  1  TX FIFO empty and TX FSM in IDLE
rx_overrun  out  1  sticky: received word dropped because RX FIFO was full
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
err_clr  in  1  clears all sticky flags

Behaviour:
- Reset values: UART_TXD=1, tx_full=0, rx_empty=1, tx_idle=1, all sticky flags=0, receive_data=0. Both FIFOs are emptied.
- Reset is honoured mid-frame; the FSMs return to IDLE immediately with no partial frame completion.
- FIFOs: circular buffers with occupancy counters.
  - WE while full is ignored.
  - RE while empty is ignored; receive_data holds its value.
  - Simultaneous push and pop on a full or empty FIFO both succeed. A pop on empty plus a push stores only the push.
  - Pointers wrap at DEPTH.
- Baud counter: counts 0..CLKS_PER_BIT-1. It is reset on every FSM state change.
- TX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: if the TX FIFO is not empty, pop it and enter START. UART_TXD goes low on the same edge (registered output).
  - A WE at edge E0 into an empty, idle block gives TXD low from E1.
  - DATA: shifts LSB first, DATA_BITS bits.
  - STOP: holds TXD high for STOP_BITS*CLKS_PER_BIT clocks.
  - From STOP, if the FIFO is not empty, go directly to START (back-to-back frames, no extra idle bit).
- RX path: UART_RXD passes through a 2-flop synchroniser first.
- RX FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised low enters START.
  - START: re-samples at count CLKS_PER_BIT/2. If high, the event is a glitch: return to IDLE and push nothing.
  - After START, all bits are sampled at mid-bit, LSB first.
  - STOP: samples only the first stop bit.
    - If low: set frame_err, discard the word, return to IDLE.
    - Else if the RX FIFO is full and no RE occurs that cycle: set rx_overrun and drop the word. FIFO contents are unchanged.
    - Else push the word.
- Sticky flags: err_clr clears all flags. If err_clr and a set event coincide in the same cycle, the set wins.

Optional Feature:
UART_PARITY_EN
- Defined:
  - TX inserts one parity bit after the data bits (even parity, or odd if PARITY_ODD=1).
  - RX samples the parity bit and sets parity_err on mismatch.
  - A parity-failed word is still pushed, unless a framing error occurred.
- Undefined:
  - No parity bit on TX or RX.
  - parity_err is tied to 0.
  - PARITY_ODD is ignored.

Test Plan:
1. CLKS_PER_BIT=16; WE with send_data=8'hA5 → UART_TXD low at the next edge, then 1,0,1,0,0,1,0,1, then high. Each level lasts 16 clk; tx_idle=1 after 160 clk.
2. Loop UART_TXD→UART_RXD; write 8'h00, 8'hFF, 8'h3C back-to-back → rx_empty falls after the first frame. Three RE pops return 00, FF, 3C; no error flags set.
3. FIFO_RX_DEPTH=4; drive 5 frames 8'h01..8'h05 with no RE → rx_overrun=1. RE pops return 01..04, then rx_empty=1. err_clr clears rx_overrun.
4. Drive a frame with stop bit 0 → frame_err=1 and rx_empty stays 1. Drive a 4-clk low glitch on RXD → no push, no flag.
5. Assert rst mid-DATA of an 8'hFF transmit with 3 words queued → UART_TXD=1 and tx_idle=1 immediately. No further frames follow after rst is deasserted.
6. With UART_PARITY_EN, PARITY_ODD=0; send 8'h07 → parity bit 1 on TXD. Inject a frame with a flipped parity bit → parity_err=1 and the word is pushed.
